// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot code path (encoder and decoder sides).
// Functions work on a code zero-extended to OH_MAX_W bits. This lets one
// function body serve every code width up to that limit.
package onehot_pkg;

  // Widest one-hot code either side of the path may use.
  localparam int OH_MAX_W     = 64;
  localparam int OH_IDX_MAX_W = 6;

  // Classification of a received code word.
  typedef enum logic [1:0] {
    CODE_ZERO   = 2'd0,
    CODE_ONEHOT = 2'd1,
    CODE_MULTI  = 2'd2
  } code_class_e;

  // Decoded result, sized for the widest supported code.
  typedef struct packed {
    logic [OH_IDX_MAX_W-1:0] idx;
    logic                    err;
  } oh_result_t;

  // Count the set bits and bucket the word: none, exactly one, or several.
  function automatic code_class_e classify(input logic [OH_MAX_W-1:0] code);
    int unsigned n_set;
    code_class_e cls;
    n_set = 0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      n_set += {31'd0, code[i]};
    end
    if (n_set == 0)      cls = CODE_ZERO;
    else if (n_set == 1) cls = CODE_ONEHOT;
    else                 cls = CODE_MULTI;
    return cls;
  endfunction

  // Index of the lowest set bit. Returns 0 for an all-zero word.
  function automatic logic [OH_IDX_MAX_W-1:0] lsb_index(input logic [OH_MAX_W-1:0] code);
    logic [OH_IDX_MAX_W-1:0] idx;
    idx = '0;
    // Scan from the top down so that the lowest set bit is the last one written.
    for (int i = OH_MAX_W - 1; i >= 0; i--) begin
      if (code[i]) idx = OH_IDX_MAX_W'(i);
    end
    return idx;
  endfunction

  // Encoder side: binary index to one-hot code word.
  function automatic logic [OH_MAX_W-1:0] encode_onehot(input logic [OH_IDX_MAX_W-1:0] idx);
    return OH_MAX_W'(1) << idx;
  endfunction

endpackage

// File: rtl/onehot_skid_buf.sv
// Two-entry skid buffer with registered outputs.
//
// Handshake, push and pop sides: a transfer happens on a rising edge where
// valid and ready are both 1. Valid does not depend on ready. The payload
// is held while valid is 1 and ready is 0.
//
// o_push_ready is a register. It is 0 during reset and is written on every
// edge with (occupancy after this edge < 2). Because of this, a push never
// arrives at a full buffer. With the pop side always ready, occupancy stays
// at 1 and the buffer passes one word per cycle.
module onehot_skid_buf #(
  parameter int DATA_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push_valid,
  output logic              o_push_ready,
  input  logic [DATA_W-1:0] i_push_data,
  output logic              o_pop_valid,
  input  logic              i_pop_ready,
  output logic [DATA_W-1:0] o_pop_data
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_occ;
  logic              r_ready;

  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_occ_next;

  assign w_push = i_push_valid & r_ready;
  assign w_pop  = (r_occ != 2'd0) & i_pop_ready;

  // Occupancy after this edge: push alone grows it, pop alone shrinks it.
  always_comb begin
    w_occ_next = r_occ;
    if (w_push && !w_pop)      w_occ_next = r_occ + 2'd1;
    else if (!w_push && w_pop) w_occ_next = r_occ - 2'd1;
  end

  // Storage, occupancy and registered ready. Reset empties the buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= 2'd0;
      r_ready <= 1'b0;
    end else begin
      r_occ   <= w_occ_next;
      r_ready <= (w_occ_next != 2'd2);
      if (w_push && !w_pop) begin
        // Fill the first free slot.
        if (r_occ == 2'd0) r_head <= i_push_data;
        else               r_tail <= i_push_data;
      end else if (!w_push && w_pop) begin
        // The tail moves up to the head. A stale tail is harmless when occupancy was 1.
        r_head <= r_tail;
      end else if (w_push && w_pop) begin
        // Occupancy does not change: the head leaves and the new word joins the queue.
        if (r_occ == 2'd1) begin
          r_head <= i_push_data;
        end else begin
          r_head <= r_tail;
          r_tail <= i_push_data;
        end
      end
    end
  end

  assign o_push_ready = r_ready;
  assign o_pop_valid  = (r_occ != 2'd0);
  assign o_pop_data   = r_head;

endmodule

// File: rtl/onehot_index_decoder.sv
// Decodes one-hot code words back into binary indices.
//
// Handshake, input and output sides: a word is taken on a rising edge where
// valid and ready are both 1. Valid never depends on ready. The output
// payload holds while o_valid is 1 and i_ready is 0.
//
// Each accepted word is classified:
// - all-zero: the encoder's hold code. It is consumed silently.
// - legal one-hot: its index goes to the output.
// - multi-hot: the index of its lowest set bit goes out with o_err set, and
//   the word is counted in the sticky flag and the saturating counter.
// Results go through a two-entry skid buffer. The output therefore comes
// straight from registers, and one word per cycle is possible.
module onehot_index_decoder
  import onehot_pkg::*;
#(
  parameter  int OH_W      = 4,
  parameter  int ERR_CNT_W = 8,
  localparam int IDX_W     = $clog2(OH_W)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [OH_W-1:0]      i_onehot,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [IDX_W-1:0]     o_index,
  output logic                 o_err,
  input  logic                 i_err_clr,
  output logic                 o_err_sticky,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  logic [OH_MAX_W-1:0]  w_code_ext;
  code_class_e          w_class;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_is_multi;
  logic                 w_push_valid;
  logic                 w_ready;
  logic                 w_accept_multi;

  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_count;

  // Zero-extend the code so the package helpers can work on it.
  always_comb begin
    w_code_ext             = '0;
    w_code_ext[OH_W-1:0]   = i_onehot;
  end

  assign w_class    = classify(w_code_ext);
  assign w_idx      = IDX_W'(lsb_index(w_code_ext));
  assign w_is_multi = (w_class == CODE_MULTI);

  // A zero word is taken whenever the buffer is ready, but it never enters the buffer.
  assign w_push_valid   = i_valid & (w_class != CODE_ZERO);
  assign w_accept_multi = i_valid & w_ready & w_is_multi;

  onehot_skid_buf #(
    .DATA_W (IDX_W + 1)
  ) u_skid (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push_valid (w_push_valid),
    .o_push_ready (w_ready),
    .i_push_data  ({w_idx, w_is_multi}),
    .o_pop_valid  (o_valid),
    .i_pop_ready  (i_ready),
    .o_pop_data   ({o_index, o_err})
  );

  // Error tracking. If an accepted multi-hot word and a clear arrive together,
  // the clear is applied first and the new error then counts as one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else if (w_accept_multi) begin
      r_err_sticky <= 1'b1;
      if (i_err_clr)                       r_err_count <= ERR_CNT_W'(1);
      else if (r_err_count != ERR_CNT_MAX) r_err_count <= r_err_count + ERR_CNT_W'(1);
    end else if (i_err_clr) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end
  end

  assign o_ready      = w_ready;
  assign o_err_sticky = r_err_sticky;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_onehot_index_decoder.sv
// Randomized and directed stimulus for onehot_index_decoder.
// A queue-based reference model tracks the expected results, the ready flag,
// and the error flag and counter.
module tb_onehot_index_decoder;
  import onehot_pkg::*;

  localparam int OH_W      = 4;
  localparam int IDX_W     = 2;
  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = 255;

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic [OH_W-1:0]      i_onehot;
  logic                 o_valid;
  logic                 i_ready;
  logic [IDX_W-1:0]     o_index;
  logic                 o_err;
  logic                 i_err_clr;
  logic                 o_err_sticky;
  logic [ERR_CNT_W-1:0] o_err_count;

  onehot_index_decoder #(
    .OH_W      (OH_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_onehot     (i_onehot),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_index      (o_index),
    .o_err        (o_err),
    .i_err_clr    (i_err_clr),
    .o_err_sticky (o_err_sticky),
    .o_err_count  (o_err_count)
  );

  // Clock and watchdog
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model state: each queue entry is {idx, err}
  logic [IDX_W:0] exp_q[$];
  bit             m_ready;
  bit             m_sticky;
  int             m_count;
  int             n_checks;
  int             n_errors;
  int             dut_results;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Index of the lowest set bit, computed by isolating that bit arithmetically
  function automatic int ref_idx(input logic [OH_W-1:0] code);
    int c;
    int low;
    c   = int'(code);
    low = c & -c;
    return $clog2(low);
  endfunction

  // One clock: check outputs mid-cycle, advance the model, cross the edge
  task automatic step();
    bit             accept;
    bit             multi;
    logic [IDX_W:0] ent;
    @(negedge i_clk);
    check_eq("o_valid", 32'(o_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      ent = exp_q[0];
      check_eq("o_index", 32'(o_index), 32'(ent[IDX_W:1]));
      check_eq("o_err", 32'(o_err), 32'(ent[0]));
    end
    check_eq("o_ready", 32'(o_ready), 32'(m_ready));
    check_eq("o_err_sticky", 32'(o_err_sticky), 32'(m_sticky));
    check_eq("o_err_count", 32'(o_err_count), 32'(m_count));
    if (o_valid && i_ready) dut_results++;

    accept = i_valid && m_ready;
    multi  = ($countones(i_onehot) >= 2);
    if (exp_q.size() > 0 && i_ready) void'(exp_q.pop_front());
    if (accept && i_onehot != '0) exp_q.push_back({IDX_W'(ref_idx(i_onehot)), multi});
    if (accept && multi) begin
      m_sticky = 1'b1;
      m_count  = i_err_clr ? 1 : ((m_count < CNT_MAX) ? m_count + 1 : CNT_MAX);
    end else if (i_err_clr) begin
      m_sticky = 1'b0;
      m_count  = 0;
    end
    m_ready = (exp_q.size() < 2);
    @(posedge i_clk);
    #1;
  endtask

  // Assert reset, check that the outputs clear at once, then release it
  task automatic apply_reset();
    i_rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 32'(o_valid), 32'd0);
    check_eq("rst_async_ready", 32'(o_ready), 32'd0);
    check_eq("rst_async_index", 32'(o_index), 32'd0);
    exp_q.delete();
    m_ready  = 1'b0;
    m_sticky = 1'b0;
    m_count  = 0;
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_hold_valid", 32'(o_valid), 32'd0);
    check_eq("rst_hold_ready", 32'(o_ready), 32'd0);
    check_eq("rst_hold_count", 32'(o_err_count), 32'd0);
    check_eq("rst_hold_sticky", 32'(o_err_sticky), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check_eq("rel_ready_before_edge", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    #1;
    check_eq("rel_ready_after_edge", 32'(o_ready), 32'd1);
    check_eq("rel_no_spurious", 32'(o_valid), 32'd0);
    m_ready = 1'b1;
  endtask

  task automatic send(input logic [OH_W-1:0] code);
    i_valid  = 1'b1;
    i_onehot = code;
    step();
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [OH_W-1:0]     codes[4];
    logic [OH_MAX_W-1:0] enc;
    int                  base;
    int                  idx;
    int                  r;

    n_checks    = 0;
    n_errors    = 0;
    dut_results = 0;
    i_rst_n     = 1'b0;
    i_valid     = 1'b1;
    i_onehot    = 4'h4;
    i_ready     = 1'b1;
    i_err_clr   = 1'b0;

    // Reset while a word is offered
    apply_reset();
    i_valid = 1'b0;
    idle(2);

    // Back-to-back legal codes
    codes = '{4'h1, 4'h2, 4'h4, 4'h8};
    base  = dut_results;
    foreach (codes[k]) send(codes[k]);
    idle(3);
    check_eq("stream_results", 32'(dut_results - base), 32'd4);

    // A zero word between two legal codes yields no result
    base = dut_results;
    send(4'h2);
    send(4'h0);
    send(4'h8);
    idle(3);
    check_eq("zero_results", 32'(dut_results - base), 32'd2);
    check_eq("zero_no_sticky", 32'(o_err_sticky), 32'd0);

    // Multi-hot code
    send(4'h6);
    idle(1);
    check_eq("multi_sticky", 32'(o_err_sticky), 32'd1);
    check_eq("multi_count", 32'(o_err_count), 32'd1);

    // The counter saturates
    for (int k = 0; k < 300; k++) send(4'hF);
    idle(3);
    check_eq("count_saturated", 32'(o_err_count), 32'(CNT_MAX));

    // A clear in the same cycle as a multi-hot word
    i_err_clr = 1'b1;
    send(4'h3);
    i_err_clr = 1'b0;
    idle(2);
    check_eq("clr_multi_sticky", 32'(o_err_sticky), 32'd1);
    check_eq("clr_multi_count", 32'(o_err_count), 32'd1);
    i_err_clr = 1'b1;
    idle(1);
    i_err_clr = 1'b0;
    idle(1);
    check_eq("clr_sticky", 32'(o_err_sticky), 32'd0);
    check_eq("clr_count", 32'(o_err_count), 32'd0);

    // Backpressure
    i_ready = 1'b0;
    send(4'h1);
    send(4'h2);
    check_eq("bp_ready_low", 32'(o_ready), 32'd0);
    send(4'h4);
    send(4'h4);
    check_eq("bp_index_held", 32'(o_index), 32'd0);
    base    = dut_results;
    i_ready = 1'b1;
    send(4'h4);
    send(4'h4);
    idle(4);
    check_eq("bp_results", 32'(dut_results - base), 32'd3);

    // Encode then decode round-trip with one-cycle latency
    for (int k = 0; k < 16; k++) begin
      idx = $urandom_range(0, OH_W - 1);
      enc = encode_onehot(OH_IDX_MAX_W'(idx));
      send(enc[OH_W-1:0]);
      check_eq("rt_valid", 32'(o_valid), 32'd1);
      check_eq("rt_index", 32'(o_index), 32'(idx));
      idle(1);
    end

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      r         = $urandom_range(0, 9);
      i_valid   = ($urandom_range(0, 3) != 0);
      if (r < 2)      i_onehot = 4'h0;
      else if (r < 7) i_onehot = OH_W'(1 << $urandom_range(0, OH_W - 1));
      else            i_onehot = OH_W'($urandom_range(0, 15));
      i_ready   = ($urandom_range(0, 3) != 0);
      i_err_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    i_err_clr = 1'b0;
    i_ready   = 1'b1;
    idle(3);

    // Reset with two results buffered
    i_ready = 1'b0;
    send(4'h1);
    send(4'h2);
    i_valid = 1'b0;
    check_eq("pre_rst_valid", 32'(o_valid), 32'd1);
    apply_reset();
    i_ready = 1'b1;
    base    = dut_results;
    idle(4);
    check_eq("post_rst_no_stale", 32'(dut_results - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
